// File: rtl/gf_pkg.sv
// Shared GF(2^m) definitions: control-state encoding, the AES field polynomial
// and a width-generic xtime helper used by the digit-serial datapaths.
package gf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_state_e;

  localparam logic [8:0] AES_POLY = 9'h11B;

  // Widest field any caller may use; operands are zero-extended to this width.
  localparam int GF_MAX_W = 128;

  // Multiply v by x modulo the field polynomial. poly holds only the low w
  // coefficients (the implicit x^w term is dropped); bits at and above w are
  // cleared so the result always stays w bits wide.
  function automatic logic [GF_MAX_W-1:0] gf_xtime(
    input logic [GF_MAX_W-1:0] v,
    input logic [GF_MAX_W-1:0] poly,
    input int                  w
  );
    logic [GF_MAX_W-1:0] mask;
    logic [GF_MAX_W-1:0] r;
    logic                msb;
    mask = (GF_MAX_W'(1) << w) - GF_MAX_W'(1);
    msb  = |(v & (GF_MAX_W'(1) << (w - 1)));
    r    = v << 1;
    if (msb) r = r ^ poly;
    return r & mask;
  endfunction

endpackage

// File: rtl/gf_digit_step.sv
// One digit of a MSB-first shift-and-add GF(2^W) multiply: D chained
// xtime/conditional-add stages, purely combinational.
module gf_digit_step
  import gf_pkg::*;
#(
  parameter int         W    = 8,
  parameter int         D    = 1,
  parameter logic [W:0] POLY = AES_POLY
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] a,
  input  logic [D-1:0] digit,
  output logic [W-1:0] acc_next
);

  localparam logic [GF_MAX_W-1:0] POLY_EXT = GF_MAX_W'(POLY[W-1:0]);

  logic [GF_MAX_W-1:0] a_ext;
  logic [GF_MAX_W-1:0] t;

  assign a_ext = GF_MAX_W'(a);

  always_comb begin
    t = GF_MAX_W'(acc);
    // digit[D-1] is the most significant multiplier bit of this slice
    for (int j = D - 1; j >= 0; j--) begin
      t = gf_xtime(t, POLY_EXT, W) ^ (digit[j] ? a_ext : '0);
    end
    acc_next = t[W-1:0];
  end

endmodule

// File: rtl/gf_mult_serial.sv
// Digit-serial GF(2^W) multiplier / multiply-accumulate with valid/ready on
// both sides; consumes D multiplier bits per clock, one operation in flight.
module gf_mult_serial
  import gf_pkg::*;
#(
  parameter int         W    = 8,
  parameter logic [W:0] POLY = AES_POLY,
  parameter int         D    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [W-1:0] in_c,
  input  logic         in_mac,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_p,
  output logic         busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is a decode of state only; out_valid, once raised,
  // holds with out_p stable until out_ready completes the transfer.

  localparam int NDIG = W / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  if (W < 2 || D < 1 || (W % D) != 0 || W > GF_MAX_W || POLY[W] != 1'b1) begin : g_bad_params
    $error("gf_mult_serial: illegal parameters W=%0d D=%0d POLY=%0h", W, D, POLY);
  end

  gf_state_e     state, state_nxt;
  logic [W-1:0]  a_q, b_q, c_q, acc_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  acc_next;
  logic          accept;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;

  gf_digit_step #(.W(W), .D(D), .POLY(POLY)) u_step (
    .acc      (acc_q),
    .a        (a_q),
    .digit    (b_q[W-1 -: D]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)         state_nxt = RUN;
      RUN:     if (cnt_q == '0)    state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      out_p <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= in_a;
            b_q   <= in_b;
            c_q   <= in_mac ? in_c : '0;
            acc_q <= '0;
            cnt_q <= CNT_LAST;
          end
        end
        RUN: begin
          acc_q <= acc_next;
          b_q   <= b_q << D;
          cnt_q <= cnt_q - CW'(1);
          // out_p only ever changes here, so it never shows a partial product
          if (cnt_q == '0) out_p <= acc_next ^ c_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_mult_serial.sv
// Bench for gf_mult_serial: four instances (W=8 D=1/4/8, W=4 D=2) driven
// through indexed signal arrays, results checked against an expected queue.
module tb_gf_mult_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid[4];
  logic       out_ready[4];
  logic       in_mac[4];
  logic [7:0] in_a[4];
  logic [7:0] in_b[4];
  logic [7:0] in_c[4];
  logic       in_ready[4];
  logic       out_valid[4];
  logic       busy[4];
  logic [7:0] out_p[4];
  logic [3:0] out_p4;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int         lat_t[4]  = '{8, 2, 1, 2};
  int         w_t[4]    = '{8, 8, 8, 4};
  logic [8:0] poly_t[4] = '{9'h11B, 9'h11B, 9'h11B, 9'h013};

  always #5 clk = ~clk;

  assign out_p[3] = {4'h0, out_p4};

  gf_mult_serial #(.W(8), .POLY(9'h11B), .D(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .in_c(in_c[0]), .in_mac(in_mac[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_p(out_p[0]), .busy(busy[0]));

  gf_mult_serial #(.W(8), .POLY(9'h11B), .D(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .in_c(in_c[1]), .in_mac(in_mac[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_p(out_p[1]), .busy(busy[1]));

  gf_mult_serial #(.W(8), .POLY(9'h11B), .D(8)) u_d8 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .in_c(in_c[2]), .in_mac(in_mac[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_p(out_p[2]), .busy(busy[2]));

  gf_mult_serial #(.W(4), .POLY(5'h13), .D(2)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_a(in_a[3][3:0]), .in_b(in_b[3][3:0]), .in_c(in_c[3][3:0]), .in_mac(in_mac[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_p(out_p4), .busy(busy[3]));

  // Reference: full carry-less product, then long division by the polynomial.
  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic mac,
                                        input int w, input logic [8:0] poly);
    logic [15:0] p;
    logic [15:0] mask;
    p = '0;
    for (int i = 0; i < w; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 2 * w - 2; i >= w; i--) if (p[i]) p = p ^ (16'(poly) << (i - w));
    mask = (16'd1 << w) - 16'd1;
    if (mac) p = p ^ 16'(c);
    p = p & mask;
    return p[7:0];
  endfunction

  task automatic issue(input int k, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic mac, input logic [7:0] e);
    int n;
    n = 0;
    while (in_ready[k] !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready[k] !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait k=%0d in_ready=%b expected 1", k, in_ready[k]);
    end
    in_valid[k] = 1'b1;
    in_a[k] = a; in_b[k] = b; in_c[k] = c; in_mac[k] = mac;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    in_valid[k] = 1'b0;
    in_a[k] = 8'($urandom); in_b[k] = 8'($urandom);
    in_c[k] = 8'($urandom); in_mac[k] = 1'($urandom);
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (out_valid[k] !== 1'b1 && n < lat_t[k] + 4) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid[k] !== 1'b1 || n != lat_t[k]) begin
      errors++;
      $display("FAIL latency k=%0d cycles=%0d out_valid=%b expected %0d", k, n, out_valid[k], lat_t[k]);
    end
  endtask

  task automatic check_and_release(input int k);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++;
    if (out_p[k] !== e) begin
      errors++;
      $display("FAIL result k=%0d out_p=%h expected %h", k, out_p[k], e);
    end
    out_ready[k] = 1'b1;
    @(posedge clk); #1;
    out_ready[k] = 1'b0;
    checks++;
    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
      errors++;
      $display("FAIL handshake k=%0d out_valid=%b in_ready=%b busy=%b expected 0 1 0",
               k, out_valid[k], in_ready[k], busy[k]);
    end
  endtask

  task automatic run_op(input int k, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic mac, input logic [7:0] e);
    issue(k, a, b, c, mac, e);
    wait_valid(k);
    check_and_release(k);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b0; in_mac[k] = 1'b0;
      in_a[k] = '0; in_b[k] = '0; in_c[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0 || out_p[k] !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold k=%0d in_ready=%b out_valid=%b busy=%b out_p=%h expected 0 0 0 00",
                 k, in_ready[k], out_valid[k], busy[k], out_p[k]);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready[k] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release k=%0d in_ready=%b expected 1", k, in_ready[k]);
      end
    end
  endtask

  task automatic test_basic;
    run_op(0, 8'h57, 8'h83, 8'h00, 1'b0, 8'hC1);
    run_op(0, 8'h57, 8'h13, 8'h00, 1'b0, 8'hFE);
    run_op(0, 8'h01, 8'hAB, 8'h00, 1'b0, 8'hAB);
    run_op(0, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic test_mac;
    run_op(0, 8'h57, 8'h83, 8'h01, 1'b1, 8'hC0);
    run_op(0, 8'h57, 8'h83, 8'hFF, 1'b0, 8'hC1);
  endtask

  task automatic test_digit_sizes;
    for (int k = 1; k <= 2; k++) begin
      run_op(k, 8'h57, 8'h83, 8'h00, 1'b0, 8'hC1);
      run_op(k, 8'h01, 8'hAB, 8'h00, 1'b0, 8'hAB);
      run_op(k, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00);
      run_op(k, 8'h57, 8'h83, 8'h01, 1'b1, 8'hC0);
    end
    run_op(3, 8'h07, 8'h0B, 8'h00, 1'b0, 8'h04);
  endtask

  task automatic test_random;
    logic [7:0] a, b, c, m;
    logic       mac;
    for (int k = 0; k < 4; k++) begin
      m = (w_t[k] == 8) ? 8'hFF : 8'h0F;
      for (int i = 0; i < 6; i++) begin
        a = 8'($urandom) & m; b = 8'($urandom) & m; c = 8'($urandom) & m;
        mac = 1'($urandom_range(0, 1));
        run_op(k, a, b, c, mac, gf_ref(a, b, c, mac, w_t[k], poly_t[k]));
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++)
      run_op(1, 8'(8'h11 * i + 8'h3), 8'(8'hC5 ^ i), 8'h00, 1'b0,
             gf_ref(8'(8'h11 * i + 8'h3), 8'(8'hC5 ^ i), 8'h00, 1'b0, 8, 9'h11B));
  endtask

  task automatic test_backpressure;
    issue(0, 8'h57, 8'h83, 8'h00, 1'b0, 8'hC1);
    wait_valid(0);
    for (int i = 0; i < 3; i++) begin
      in_valid[0] = 1'b1; in_a[0] = 8'h12; in_b[0] = 8'h34; in_mac[0] = 1'b0;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      checks++;
      if (out_valid[0] !== 1'b1 || out_p[0] !== 8'hC1 || in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
        errors++;
        $display("FAIL backpressure cyc=%0d out_valid=%b out_p=%h in_ready=%b busy=%b expected 1 c1 0 1",
                 i, out_valid[0], out_p[0], in_ready[0], busy[0]);
      end
    end
    check_and_release(0);
    @(posedge clk); #1;
    checks++;
    if (busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_restart busy=%b out_valid=%b expected 0 0", busy[0], out_valid[0]);
    end
  endtask

  task automatic test_reset_mid_run;
    issue(0, 8'hFF, 8'hFF, 8'hA5, 1'b1, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || out_p[0] !== 8'h00 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run out_valid=%b out_p=%h busy=%b in_ready=%b expected 0 00 0 0",
               out_valid[0], out_p[0], busy[0], in_ready[0]);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(0, 8'h57, 8'h13, 8'h00, 1'b0, 8'hFE);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mac();
    test_digit_sizes();
    test_back_to_back();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
